// File: rtl/gan_frame_reader.sv
// rtl/gan_frame_reader.sv - snapshot and stream reader for the GAN generator/discriminator outputs
//
// Purpose: captures nine generator pixels and the discriminator score in one
// cycle, then streams the ten Q8.24 words one per valid/ready handshake.
// It also registers the discriminator decision against THRESH.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   capture_valid       capture request (honoured only while capture_ready)
//   capture_ready       high while idle
//   pixel_1x1..3x3      generator pixels, signed Q8.24
//   disc_in             discriminator score, signed Q8.24
//   out_data/out_valid  streamed word and its valid flag
//   out_ready           consumer accept
//   out_index/out_last  word index 0-9, high on index 9
//   disc_real           registered disc_in >= THRESH (signed)
//   frame_count         completed frames, wraps at 16 bits
module gan_frame_reader #(
   parameter int                        WIDTH  = 32,
   parameter logic signed [WIDTH-1:0]   THRESH = 32'h00800000,
   parameter bit                        CLAMP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture_valid,
   output logic             capture_ready,
   input  logic [WIDTH-1:0] pixel_1x1,
   input  logic [WIDTH-1:0] pixel_1x2,
   input  logic [WIDTH-1:0] pixel_1x3,
   input  logic [WIDTH-1:0] pixel_2x1,
   input  logic [WIDTH-1:0] pixel_2x2,
   input  logic [WIDTH-1:0] pixel_2x3,
   input  logic [WIDTH-1:0] pixel_3x1,
   input  logic [WIDTH-1:0] pixel_3x2,
   input  logic [WIDTH-1:0] pixel_3x3,
   input  logic [WIDTH-1:0] disc_in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_index,
   output logic             out_last,
   output logic             disc_real,
   output logic [15:0]      frame_count
);

   localparam int                      NUM_WORDS = 10;
   localparam logic [3:0]              LAST_IDX  = 4'd9;
   localparam logic signed [WIDTH-1:0] ONE_Q     = WIDTH'(32'h01000000);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q [NUM_WORDS];
   logic [WIDTH-1:0] cap_word [NUM_WORDS];
   logic [WIDTH-1:0] pix [9];
   logic [3:0]       idx_q;
   logic             disc_real_q;
   logic [15:0]      frame_cnt_q;
   logic             capture;
   logic             fire;

   function automatic logic [WIDTH-1:0] clamp_px(input logic [WIDTH-1:0] v);
      if (!CLAMP)
         return v;
      if ($signed(v) < 0)
         return '0;
      if ($signed(v) > ONE_Q)
         return ONE_Q;
      return v;
   endfunction

   assign pix[0] = pixel_1x1;
   assign pix[1] = pixel_1x2;
   assign pix[2] = pixel_1x3;
   assign pix[3] = pixel_2x1;
   assign pix[4] = pixel_2x2;
   assign pix[5] = pixel_2x3;
   assign pix[6] = pixel_3x1;
   assign pix[7] = pixel_3x2;
   assign pix[8] = pixel_3x3;

   // Raster-ordered capture image; the discriminator word is never clamped.
   always_comb begin
      for (int i = 0; i < 9; i++)
         cap_word[i] = clamp_px(pix[i]);
      cap_word[9] = disc_in;
   end

   assign capture = (state_q == IDLE) && capture_valid;
   assign fire    = (state_q == SEND) && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (capture_valid) state_d = SEND;
         SEND: if (out_ready && idx_q == LAST_IDX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++)
            word_q[i] <= '0;
         idx_q       <= '0;
         disc_real_q <= 1'b0;
         frame_cnt_q <= '0;
      end else if (capture) begin
         for (int i = 0; i < NUM_WORDS; i++)
            word_q[i] <= cap_word[i];
         disc_real_q <= $signed(disc_in) >= THRESH;
         idx_q       <= '0;
      end else if (fire) begin
         if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end else begin
            idx_q <= idx_q + 4'd1;
         end
      end
   end

   // Output word is selected from registered state only; zero while idle.
   always_comb begin
      out_data = '0;
      if (state_q == SEND)
         for (int i = 0; i < NUM_WORDS; i++)
            if (idx_q == 4'(i))
               out_data = word_q[i];
   end

   assign capture_ready = (state_q == IDLE);
   assign out_valid     = (state_q == SEND);
   assign out_index     = idx_q;
   assign out_last      = (state_q == SEND) && (idx_q == LAST_IDX);
   assign disc_real     = disc_real_q;
   assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_gan_frame_reader.sv
// tb/tb_gan_frame_reader.sv - self-checking bench for gan_frame_reader
module tb_gan_frame_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        capture_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] pix [9];
   logic [31:0] disc_in = '0;

   logic        capture_ready, out_valid, out_last, disc_real;
   logic [31:0] out_data;
   logic [3:0]  out_index;
   logic [15:0] frame_count;

   logic        r_capture_ready, r_out_valid, r_out_last, r_disc_real;
   logic [31:0] r_out_data;
   logic [3:0]  r_out_index;
   logic [15:0] r_frame_count;

   int          total = 0;
   int          bad = 0;
   logic [15:0] fc_model = 16'd0;

   always #5 clk = ~clk;

   gan_frame_reader #(.CLAMP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .capture_valid(capture_valid), .capture_ready(capture_ready),
      .pixel_1x1(pix[0]), .pixel_1x2(pix[1]), .pixel_1x3(pix[2]),
      .pixel_2x1(pix[3]), .pixel_2x2(pix[4]), .pixel_2x3(pix[5]),
      .pixel_3x1(pix[6]), .pixel_3x2(pix[7]), .pixel_3x3(pix[8]),
      .disc_in(disc_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_last(out_last),
      .disc_real(disc_real), .frame_count(frame_count)
   );

   gan_frame_reader #(.CLAMP(1'b0)) dut_raw (
      .clk(clk), .rst_n(rst_n),
      .capture_valid(capture_valid), .capture_ready(r_capture_ready),
      .pixel_1x1(pix[0]), .pixel_1x2(pix[1]), .pixel_1x3(pix[2]),
      .pixel_2x1(pix[3]), .pixel_2x2(pix[4]), .pixel_2x3(pix[5]),
      .pixel_3x1(pix[6]), .pixel_3x2(pix[7]), .pixel_3x3(pix[8]),
      .disc_in(disc_in),
      .out_data(r_out_data), .out_valid(r_out_valid), .out_ready(out_ready),
      .out_index(r_out_index), .out_last(r_out_last),
      .disc_real(r_disc_real), .frame_count(r_frame_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference clamp: numeric range check on the signed Q8.24 value.
   function automatic logic [31:0] model_clamp(input logic [31:0] v);
      int s;
      s = $signed(v);
      if (s < 0) return 32'h0;
      if (s > 16777216) return 32'h01000000;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".cap_ready"}, {31'b0, capture_ready}, 32'd1);
      chk({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, ".fc"}, {16'b0, frame_count}, {16'b0, fc_model});
      chk({tag, ".raw_fc"}, {16'b0, r_frame_count}, {16'b0, fc_model});
   endtask

   // Capture current inputs, then stream the frame. busy=1 gives random
   // out_ready and scrambles inputs / asserts capture_valid during SEND.
   task automatic run_frame(input string tag, input bit busy);
      logic [31:0] exp_c [10];
      logic [31:0] exp_r [10];
      logic        exp_real;
      int k, cycles;
      for (int i = 0; i < 9; i++) begin
         exp_c[i] = model_clamp(pix[i]);
         exp_r[i] = pix[i];
      end
      exp_c[9] = disc_in;
      exp_r[9] = disc_in;
      exp_real = ($signed(disc_in) >= $signed(32'h00800000));
      check_idle({tag, ".pre"});
      capture_valid = 1'b1;
      tick();
      capture_valid = 1'b0;
      chk({tag, ".disc_real"}, {31'b0, disc_real}, {31'b0, exp_real});
      chk({tag, ".raw_disc_real"}, {31'b0, r_disc_real}, {31'b0, exp_real});
      k = 0;
      cycles = 0;
      while (k < 10 && cycles < 200) begin
         out_ready = busy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (busy) begin
            for (int i = 0; i < 9; i++) pix[i] = $urandom;
            disc_in = $urandom;
            capture_valid = 1'($urandom_range(0, 1));
         end
         chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
         chk({tag, ".cap_ready_send"}, {31'b0, capture_ready}, 32'd0);
         chk({tag, ".data"}, out_data, exp_c[k]);
         chk({tag, ".raw_data"}, r_out_data, exp_r[k]);
         chk({tag, ".index"}, {28'b0, out_index}, k);
         chk({tag, ".last"}, {31'b0, out_last}, {31'b0, (k == 9)});
         tick();
         if (out_ready) k++;
         cycles++;
      end
      capture_valid = 1'b0;
      out_ready = 1'b0;
      chk({tag, ".timeout"}, k, 10);
      fc_model = fc_model + 16'd1;
      check_idle({tag, ".post"});
      chk({tag, ".disc_hold"}, {31'b0, disc_real}, {31'b0, exp_real});
   endtask

   task automatic set_pixels_ramp();
      for (int i = 0; i < 9; i++) pix[i] = 32'h00100000 * (i + 1);
   endtask

   initial begin
      set_pixels_ramp();
      #2;
      check_idle("reset");
      chk("reset.data", out_data, 32'h0);
      chk("reset.index", {28'b0, out_index}, 32'h0);
      chk("reset.last", {31'b0, out_last}, 32'h0);
      chk("reset.disc_real", {31'b0, disc_real}, 32'h0);
      #10;
      rst_n = 1'b1;
      tick();

      disc_in = 32'h00C00000;
      run_frame("basic", 1'b0);

      set_pixels_ramp();
      pix[0] = 32'hFF000000;
      pix[4] = 32'h02000000;
      pix[8] = 32'h01000000;
      disc_in = 32'h00800000;
      run_frame("clamp_thr_eq", 1'b0);

      disc_in = 32'h007FFFFF;
      run_frame("thr_below", 1'b0);

      disc_in = 32'hFF000000;
      run_frame("thr_neg", 1'b0);

      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 9; i++)
            pix[i] = (f % 2 == 0) ? $urandom : $urandom_range(0, 32'h01FFFFFF);
         disc_in = $urandom;
         run_frame("random_bp", 1'b1);
      end

      force dut.frame_cnt_q = 16'hFFFF;
      force dut_raw.frame_cnt_q = 16'hFFFF;
      #1;
      release dut.frame_cnt_q;
      release dut_raw.frame_cnt_q;
      fc_model = 16'hFFFF;
      set_pixels_ramp();
      disc_in = 32'h00400000;
      run_frame("wrap", 1'b0);
      chk("wrap.zero", {16'b0, frame_count}, 32'h0);

      set_pixels_ramp();
      disc_in = 32'h00C00000;
      capture_valid = 1'b1;
      tick();
      capture_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("midrst.index_before", {28'b0, out_index}, 32'd4);
      #3;
      rst_n = 1'b0;
      #1;
      fc_model = 16'd0;
      check_idle("midrst");
      chk("midrst.data", out_data, 32'h0);
      chk("midrst.index", {28'b0, out_index}, 32'h0);
      chk("midrst.last", {31'b0, out_last}, 32'h0);
      chk("midrst.disc_real", {31'b0, disc_real}, 32'h0);
      #2;
      rst_n = 1'b1;
      tick();
      check_idle("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
